// File: rtl/bit_deserializer_pkg.sv
// bit_deserializer_pkg: shared FSM state type and default word width for the bit deserializer
package bit_deserializer_pkg;
  localparam int BITDESER_MAXBITS = 32;
`ifdef BIT_DESERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif
endpackage

// File: rtl/bit_deser_shift.sv
// bit_deser_shift: shift register, bit counter and bit-order placement for bit_deserializer
// Ports: clk, rst (sync, active high), bit_in (serial bit), en (accept bit_in as a data bit),
//        clr (word complete: clear register and counter), word_next (register with bit_in
//        placed when en), last (the next data bit is the final one of the word)
module bit_deser_shift
  import bit_deserializer_pkg::*;
#(
  parameter int MAXBITS   = BITDESER_MAXBITS,
  parameter int LSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               en,
  input  logic               clr,
  output logic [MAXBITS-1:0] word_next,
  output logic               last
);
  localparam int CW = $clog2(MAXBITS + 1);
  localparam int PW = $clog2(MAXBITS);
  logic [CW-1:0]      count;
  logic [MAXBITS-1:0] data;
  logic [PW-1:0]      pos;
  // count reaches MAXBITS only while a parity bit is pending; en is low then, so the truncated pos is unused
  assign pos  = LSB_FIRST != 0 ? count[PW-1:0] : PW'(MAXBITS - 1) - count[PW-1:0];
  assign last = count == CW'(MAXBITS - 1);
  always_comb begin
    word_next = data;
    if (en) word_next[pos] = bit_in;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      data  <= '0;
    end else if (en) begin
      count <= count + 1'b1;
      data  <= word_next;
    end
  end
endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer: collects serial bits into MAXBITS-wide words with a ready/valid output register
// Ports: clk, rst (sync, active high), sin_bit/sin_valid/sin_ready (serial input handshake),
//        out_word/out_valid/out_ready (word output handshake), out_perr (parity error, qualified by out_valid)
// Build option: define BIT_DESERIALIZER_PARITY_EN to expect an even-parity bit after each word's data bits
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int MAXBITS   = BITDESER_MAXBITS,
  parameter int LSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sin_bit,
  input  logic               sin_valid,
  output logic               sin_ready,
  output logic [MAXBITS-1:0] out_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_perr
);
  state_t             state, state_next;
  logic               accept, complete, load, data_en, last;
  logic [MAXBITS-1:0] word_next;
  assign accept = sin_valid && sin_ready;
`ifdef BIT_DESERIALIZER_PARITY_EN
  assign complete = state == PAR;
  assign data_en  = accept && state != PAR;
`else
  assign complete = state == RECV && last;
  assign data_en  = accept;
`endif
  assign load = accept && complete;
  // only a word-completing bit can stall, and only while the previous word is still unclaimed
  assign sin_ready = !(complete && out_valid && !out_ready);
  bit_deser_shift #(.MAXBITS(MAXBITS), .LSB_FIRST(LSB_FIRST)) u_shift (
    .clk(clk),
    .rst(rst),
    .bit_in(sin_bit),
    .en(data_en),
    .clr(load),
    .word_next(word_next),
    .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    if (accept) begin
      if (state == IDLE) state_next = RECV;
`ifdef BIT_DESERIALIZER_PARITY_EN
      else if (state == RECV && last) state_next = PAR;
      else if (state == PAR) state_next = IDLE;
`else
      else if (state == RECV && last) state_next = IDLE;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_word  <= word_next;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef BIT_DESERIALIZER_PARITY_EN
  // in PAR word_next is the complete data word and sin_bit is the parity bit
  always_ff @(posedge clk) begin
    if (rst) out_perr <= 1'b0;
    else if (load) out_perr <= ^word_next ^ sin_bit;
  end
`else
  assign out_perr = 1'b0;
`endif
endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: scoreboard bench driving LSB-first and MSB-first 8-bit instances with shared stimulus
module tb_bit_deserializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin_bit = 1'b0;
  logic       sin_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       sin_ready_a, sin_ready_b;
  logic [7:0] out_word_a, out_word_b;
  logic       out_valid_a, out_valid_b;
  logic       out_perr_a, out_perr_b;
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         done = 0;

  always #5 clk = ~clk;

  bit_deserializer #(.MAXBITS(8), .LSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .sin_bit(sin_bit), .sin_valid(sin_valid), .sin_ready(sin_ready_a),
    .out_word(out_word_a), .out_valid(out_valid_a), .out_ready(out_ready), .out_perr(out_perr_a)
  );
  bit_deserializer #(.MAXBITS(8), .LSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .sin_bit(sin_bit), .sin_valid(sin_valid), .sin_ready(sin_ready_b),
    .out_word(out_word_b), .out_valid(out_valid_b), .out_ready(out_ready), .out_perr(out_perr_b)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rev(input logic [7:0] d);
    for (int i = 0; i < 8; i++) rev[i] = d[7-i];
  endfunction

  always @(negedge clk) begin : mon_a
    logic [8:0] e;
    if (!rst && out_valid_a && out_ready) begin
      if (qa.size() == 0) check("sb_a_extra", 1, 0);
      else begin
        e = qa.pop_front();
        check("word_a", out_word_a, e[7:0]);
        check("perr_a", out_perr_a, e[8]);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [8:0] e;
    if (!rst && out_valid_b && out_ready) begin
      if (qb.size() == 0) check("sb_b_extra", 1, 0);
      else begin
        e = qb.pop_front();
        check("word_b", out_word_b, e[7:0]);
        check("perr_b", out_perr_b, e[8]);
      end
    end
  end

  task automatic send_bit(input logic b, input bit gaps);
    int   n = 0;
    logic r = 1'b0;
    if (gaps && $urandom_range(0, 2) == 0)
      repeat ($urandom_range(1, 3)) begin
        sin_valid = 1'b0;
        sin_bit = 1'($urandom);
        @(posedge clk); #1;
      end
    sin_valid = 1'b1;
    sin_bit = b;
    do begin
      @(negedge clk);
      r = sin_ready_a;
      n++;
      @(posedge clk); #1;
    end while (!r && n < 200);
    if (!r) check("sin_timeout", 0, 1);
    sin_valid = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d, input logic flip);
    logic p;
`ifdef BIT_DESERIALIZER_PARITY_EN
    p = flip;
`else
    p = 1'b0;
`endif
    qa.push_back({p, d});
    qb.push_back({p, rev(d)});
  endtask

  task automatic send_word(input logic [7:0] d, input logic flip, input bit gaps);
    push_word(d, flip);
    for (int i = 0; i < 8; i++) send_bit(d[i], gaps);
`ifdef BIT_DESERIALIZER_PARITY_EN
    send_bit(^d ^ flip, gaps);
`endif
  endtask

  initial begin
    logic       lastb;
    logic [7:0] d;
    // reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_valid", out_valid_a, 0);
      check("idle_word", out_word_a, 8'h00);
      check("idle_ready", sin_ready_a, 1);
    end
    @(posedge clk); #1;
    // both bit orders, single-cycle valid
    send_word(8'h0D, 1'b0, 0);
    @(negedge clk);
    check("ord_valid_a", out_valid_a, 1);
    check("ord_word_a", out_word_a, 8'h0D);
    check("ord_word_b", out_word_b, 8'hB0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ord_valid_drop", out_valid_a, 0);
    @(posedge clk); #1;
    // backpressure: second word's completing bit stalls until the first is taken
    out_ready = 1'b0;
    send_word(8'hA5, 1'b0, 0);
    d = 8'h3C;
    push_word(d, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(d[i], 0);
`ifdef BIT_DESERIALIZER_PARITY_EN
    send_bit(d[7], 0);
    lastb = ^d;
`else
    lastb = d[7];
`endif
    sin_valid = 1'b1;
    sin_bit = lastb;
    @(negedge clk);
    check("bp_ready_low", sin_ready_a, 0);
    check("bp_held_a", out_word_a, 8'hA5);
    check("bp_held_b", out_word_b, 8'hA5);
    check("bp_valid", out_valid_a, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_still_held", out_word_a, 8'hA5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_high", sin_ready_a, 1);
    @(posedge clk); #1;
    sin_valid = 1'b0;
    @(negedge clk);
    check("bp_new_valid", out_valid_a, 1);
    check("bp_new_word", out_word_a, 8'h3C);
    @(posedge clk); #1;
    // mid-word reset discards the partial word
    for (int i = 0; i < 5; i++) send_bit(1'(i % 2), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid_a, 0);
    check("rst_word", out_word_a, 8'h00);
    @(posedge clk); #1;
    send_word(8'hFF, 1'b0, 0);
    send_word(8'h00, 1'b0, 0);
`ifdef BIT_DESERIALIZER_PARITY_EN
    // parity: correct and corrupted parity bit
    send_word(8'h0D, 1'b0, 0);
    send_word(8'h0D, 1'b1, 0);
`endif
    // gapped input with random consumer backpressure
    fork
      begin
        for (int w = 0; w < 32; w++) send_word(8'($urandom_range(0, 255)), 1'($urandom), 1);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_a", 64'(qa.size()), 0);
    check("drain_b", 64'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
